omi_mem_slave: RTL and testbench

OMI_MEM_SLAVE -- requirements
Module: omi_mem_slave

---
 rtl/omi_mem_slave.sv | 79 +++++++
 tb/tb_omi_mem_slave.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/omi_mem_slave.sv
// omi_mem_slave: OMI word memory slave with byte-enabled writes and fixed-latency wrapping read bursts
module omi_mem_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic                    i_wen,
  input  logic [DATA_WIDTH/8-1:0] i_ben,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [7:0]              i_len,
  output logic                    o_rdy,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data
);
  localparam int IW = ADDR_WIDTH - 2;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);
  typedef enum logic [1:0] {IDLE, ACK, WAIT, RESP} state_t;
  state_t state, nxt;
  logic armed, wr, wr_d, hs, rdy_d, valid_d;
  logic [3:0] cnt, cnt_d;
  logic [8:0] rem, rem_d;
  logic [IW-1:0] idx, idx_d, rd_idx;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] mem [2**IW];
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_addr[1:0];
  assign hs = state == ACK && i_req;
  assign rd_idx = hs ? i_addr[ADDR_WIDTH-1:2] : idx;
  // armed delays the first accept by one edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      armed   <= 1'b0;
      wr      <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      idx     <= '0;
      o_rdy   <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      state   <= nxt;
      armed   <= 1'b1;
      wr      <= wr_d;
      cnt     <= cnt_d;
      rem     <= rem_d;
      idx     <= idx_d;
      o_rdy   <= rdy_d;
      o_valid <= valid_d;
      o_data  <= data_d;
    end
  end
  always_comb begin
    nxt = state == IDLE ? (armed && i_req ? ACK : IDLE) :
          state == ACK  ? (!i_req ? IDLE : RD_LATENCY == 1 ? RESP : WAIT) :
          state == WAIT ? (cnt <= 4'd1 ? RESP : WAIT) :
                          (rem == 9'd0 ? IDLE : RESP);
  end
  // every cycle that lands in RESP emits one beat and advances the word index
  always_comb begin
    wr_d    = hs ? i_wen : wr;
    rdy_d   = nxt == ACK;
    valid_d = nxt == RESP;
    data_d  = (nxt == RESP && !wr_d) ? mem[rd_idx] : '0;
    idx_d   = rd_idx + {{(IW-1){1'b0}}, nxt == RESP};
    cnt_d   = hs ? LAT_M1 : state == WAIT ? cnt - 4'd1 : cnt;
    rem_d   = hs ? (i_wen ? 9'd0 : {1'b0, i_len}) : (state == RESP && rem != 9'd0) ? rem - 9'd1 : rem;
  end
  always_ff @(posedge clk) begin
    if (hs && i_wen)
      for (int k = 0; k < BW; k++)
        if (i_ben[k]) mem[i_addr[ADDR_WIDTH-1:2]][8*k +: 8] <= i_data[8*k +: 8];
  end
endmodule

// File: tb/tb_omi_mem_slave.sv
// tb_omi_mem_slave: scoreboard bench driving three latency variants (2, 1, 15) in lockstep
module tb_omi_mem_slave;
  logic clk = 1'b0, reset_n = 1'b0, i_req = 1'b0, i_wen = 1'b0;
  logic [9:0] i_addr = '0;
  logic [3:0] i_ben = '0;
  logic [31:0] i_data = '0;
  logic [7:0] i_len = '0;
  logic r2, v2, r1, v1, r15, v15, r_s, v_s;
  logic [31:0] d2, d1, d15, d_s;
  int sel = 0;
  int n_cmp = 0, n_err = 0;
  int lat_of [3] = '{2, 1, 15};
  logic [31:0] model [256];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  assign r_s = sel == 1 ? r1 : sel == 2 ? r15 : r2;
  assign v_s = sel == 1 ? v1 : sel == 2 ? v15 : v2;
  assign d_s = sel == 1 ? d1 : sel == 2 ? d15 : d2;

  omi_mem_slave #(.RD_LATENCY(2)) u2 (.clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr),
    .i_wen(i_wen), .i_ben(i_ben), .i_data(i_data), .i_len(i_len), .o_rdy(r2), .o_valid(v2), .o_data(d2));
  omi_mem_slave #(.RD_LATENCY(1)) u1 (.clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr),
    .i_wen(i_wen), .i_ben(i_ben), .i_data(i_data), .i_len(i_len), .o_rdy(r1), .o_valid(v1), .o_data(d1));
  omi_mem_slave #(.RD_LATENCY(15)) u15 (.clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr),
    .i_wen(i_wen), .i_ben(i_ben), .i_data(i_data), .i_len(i_len), .o_rdy(r15), .o_valid(v15), .o_data(d15));

  task automatic settle();
    repeat (20) @(negedge clk);
    for (int t = 0; t < 400 && (v1 || v2 || v15); t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic txn(input int s, input bit wen, input logic [9:0] addr, input logic [3:0] ben,
                     input logic [31:0] data, input logic [7:0] len);
    int lat, beats, nexp;
    logic [31:0] e;
    logic [7:0] w;
    sel = s;
    w = addr[9:2];
    if (wen) begin
      for (int k = 0; k < 4; k++) if (ben[k]) model[w][8*k +: 8] = data[8*k +: 8];
      exp_q.push_back('0);
    end else
      for (int n = 0; n <= int'(len); n++) exp_q.push_back(model[8'(int'(w) + n)]);
    nexp = exp_q.size();
    @(negedge clk);
    i_req = 1'b1; i_wen = wen; i_addr = addr; i_ben = ben; i_data = data; i_len = len;
    lat = 0;
    while (!r_s && lat < 10) begin @(negedge clk); lat++; end
    n_cmp++;
    if (r_s !== 1'b1) begin n_err++; $display("FAIL handshake addr=%h: o_rdy=%b required 1", addr, r_s); end
    @(posedge clk);
    #1 i_req = 1'b0; i_wen = $urandom; i_addr = $urandom; i_ben = $urandom; i_data = $urandom; i_len = $urandom;
    lat = 1;
    @(negedge clk);
    while (!v_s && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat != lat_of[s]) begin n_err++; $display("FAIL latency sel=%0d: got %0d required %0d", s, lat, lat_of[s]); end
    beats = 0;
    while (v_s && beats < 300) begin
      e = exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_cmp++;
      if (d_s !== e || r_s !== 1'b0) begin
        n_err++; $display("FAIL beat %0d addr=%h: o_data=%h o_rdy=%b required %h 0", beats, addr, d_s, r_s, e);
      end
      beats++;
      @(negedge clk);
    end
    n_cmp++;
    if (beats != nexp) begin n_err++; $display("FAIL beat count addr=%h: got %0d required %0d", addr, beats, nexp); end
    n_cmp++;
    if (d_s !== 32'h0) begin n_err++; $display("FAIL idle data: o_data=%h required 0", d_s); end
    exp_q.delete();
    settle();
  endtask

  task automatic test_reset();
    i_req = 1'b1; i_wen = 1'b1; i_ben = 4'h0; i_addr = 10'h100; i_data = 32'hFFFF_FFFF; i_len = 8'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({r1, r2, r15, v1, v2, v15} !== 6'b0 || (d1 | d2 | d15) !== 32'h0) begin
      n_err++; $display("FAIL reset outputs: rdy=%b%b%b valid=%b%b%b required all 0", r1, r2, r15, v1, v2, v15);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (r2 !== 1'b0) begin n_err++; $display("FAIL first edge rdy: o_rdy=%b required 0", r2); end
    @(negedge clk);
    n_cmp++;
    if (r2 !== 1'b1) begin n_err++; $display("FAIL second edge rdy: o_rdy=%b required 1", r2); end
    @(posedge clk);
    #1 i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (v2 !== 1'b1 || d2 !== 32'h0) begin
      n_err++; $display("FAIL ben0 write ack: valid=%b data=%h required 1 0", v2, d2);
    end
    settle();
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 10'h010, 4'hF, 32'hDEADBEEF, 8'd0);
    txn(0, 1'b0, 10'h010, 4'h0, 32'h0, 8'd0);
  endtask

  task automatic test_partial();
    txn(0, 1'b1, 10'h020, 4'hF, 32'h11223344, 8'd0);
    txn(0, 1'b1, 10'h020, 4'h5, 32'hAABBCCDD, 8'd0);
    txn(0, 1'b1, 10'h020, 4'h0, 32'hFFFFFFFF, 8'd0);
    txn(0, 1'b0, 10'h023, 4'h0, 32'h0, 8'd0);
    n_cmp++;
    if (model[8] !== 32'h11BB33DD) begin n_err++; $display("FAIL partial model: %h required 11bb33dd", model[8]); end
  endtask

  task automatic test_burst_wrap();
    txn(0, 1'b1, 10'h3F8, 4'hF, 32'd1, 8'd0);
    txn(0, 1'b1, 10'h3FC, 4'hF, 32'd2, 8'd0);
    txn(0, 1'b1, 10'h000, 4'hF, 32'd3, 8'd0);
    txn(0, 1'b0, 10'h3F8, 4'h0, 32'h0, 8'd2);
  endtask

  task automatic test_back_to_back();
    int t;
    sel = 0;
    @(negedge clk);
    i_req = 1'b1; i_wen = 1'b0; i_addr = 10'h010; i_len = 8'd0;
    t = 0;
    while (!r2 && t < 10) begin @(negedge clk); t++; end
    for (int c = 0; c < 12; c++) begin
      n_cmp++;
      if (r2 !== (c % 4 == 0) || v2 !== (c % 4 == 2) || d2 !== (c % 4 == 2 ? model[4] : 32'h0)) begin
        n_err++; $display("FAIL held req cycle %0d: rdy=%b valid=%b data=%h", c, r2, v2, d2);
      end
      @(negedge clk);
    end
    i_req = 1'b0;
    settle();
    @(negedge clk);
    i_req = 1'b1; i_wen = 1'b1; i_ben = 4'hF; i_addr = 10'h010; i_data = 32'h5555_5555;
    t = 0;
    while (!r2 && t < 10) begin @(negedge clk); t++; end
    i_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (r2 !== 1'b0) begin n_err++; $display("FAIL dropped ack rdy: o_rdy=%b required 0", r2); end
    t = 0;
    for (int c = 0; c < 25; c++) begin
      if (v2 !== 1'b0) t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t != 0) begin n_err++; $display("FAIL dropped ack valid: %0d beats required 0", t); end
    txn(0, 1'b0, 10'h010, 4'h0, 32'h0, 8'd0);
  endtask

  task automatic test_reset_mid_burst();
    int t;
    for (int a = 0; a < 8; a++) txn(0, 1'b1, 10'(10'h040 + 4 * a), 4'hF, $urandom, 8'd0);
    sel = 0;
    @(negedge clk);
    i_req = 1'b1; i_wen = 1'b0; i_addr = 10'h040; i_len = 8'd7;
    t = 0;
    while (!r2 && t < 10) begin @(negedge clk); t++; end
    @(posedge clk);
    #1 i_req = 1'b0;
    t = 0;
    while (!v2 && t < 10) begin @(negedge clk); t++; end
    for (int b = 0; b < 3; b++) begin
      n_cmp++;
      if (v2 !== 1'b1 || d2 !== model[16 + b]) begin
        n_err++; $display("FAIL pre-reset beat %0d: valid=%b data=%h required 1 %h", b, v2, d2, model[16 + b]);
      end
      @(negedge clk);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (v2 !== 1'b0 || d2 !== 32'h0) begin n_err++; $display("FAIL async abort: valid=%b data=%h required 0 0", v2, d2); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    t = 0;
    for (int c = 0; c < 20; c++) begin
      if (v2 !== 1'b0) t++;
      @(negedge clk);
    end
    n_cmp++;
    if (t != 0) begin n_err++; $display("FAIL post-reset beats: %0d required 0", t); end
    txn(0, 1'b0, 10'h040, 4'h0, 32'h0, 8'd7);
  endtask

  task automatic test_latency();
    for (int a = 0; a < 256; a++) txn(1, 1'b1, 10'(4 * a), 4'hF, $urandom, 8'd0);
    txn(1, 1'b0, 10'h010, 4'h0, 32'h0, 8'd0);
    txn(2, 1'b0, 10'h010, 4'h0, 32'h0, 8'd0);
    txn(0, 1'b0, 10'h000, 4'h0, 32'h0, 8'd255);
    txn(2, 1'b0, 10'h004, 4'h0, 32'h0, 8'd255);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_burst_wrap();
    test_back_to_back();
    test_reset_mid_burst();
    test_latency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
